imm_inst_encoder: RTL and testbench
===================================

Name: imm_inst_encoder

Overview:
- Inverse of the core's immediate decoder: packs a 32-bit immediate and register/function fields into a legal RV32I instruction word of the requested format (I/S/B/U/J).
- Also expands the LI pseudo-op into LUI+ADDI.
- Used by the debug/program-buffer path and the self-test sequencer to synthesise instructions at runtime.
- Valid/ready request in, registered valid/ready instruction stream out.

Parameters:
- ENABLE_LI, 1, 1 = accept FMT_LI requests; 0 = FMT_LI is encoded as an error NOP.
- CHECK_RANGE, 1, 1 = drive out_err on immediate range/alignment violations; 0 = out_err tied 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_fmt  in  3  format select from package enum: FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI.
- req_opcode  in  7  opcode field; ignored for FMT_LI.
- req_funct3  in  3  funct3; ignored for U/J/LI.
- req_funct7  in  7  placed in inst[31:25] only when req_fmt=FMT_I and req_funct7_en=1 (shift-immediate ops).
- req_funct7_en  in  1  see req_funct7.
- req_rd  in  5  destination register.
- req_rs1  in  5  source 1.
- req_rs2  in  5  source 2.
- req_imm  in  32  full signed immediate value (byte offset for B/J; full value for U and LI).
- out_valid  out  1  out_inst valid.
- out_ready  in  1  consumer accepts on out_valid & out_ready.
- out_inst  out  32  encoded instruction.
- out_last  out  1  final word of the current request.
- out_err  out  1  immediate unrepresentable; word still emitted with truncated bits.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values: out_valid=0, out_inst=0, out_last=0, out_err=0. FSM=IDLE. Any pending LI low word is discarded.
- Output register: single entry.
  - req_ready = ~out_valid | (out_ready & out_last) (combinational).
  - Accepted request appears on out_* the next cycle (latency 1). Full throughput of 1 word/cycle for single-word formats.
- FSM states and transitions:
  - IDLE: no word held. On accept, go to SINGLE, or to LI_HI for a two-word LI.
  - SINGLE: holds the final word (out_last=1). On out_ready: go to SINGLE/LI_HI if a new request is accepted the same cycle, else IDLE.
  - LI_HI: holds the LUI word (out_last=0); the ADDI word is held in an internal register. On out_ready, go to LI_LO. req_ready=0 in this state.
  - LI_LO: holds the ADDI word (out_last=1). Behaves as SINGLE.
- Held outputs: out_inst, out_last and out_err stay stable while out_valid & ~out_ready.
- Field packing:
  - I: imm[11:0]→[31:20]; funct7 overrides [31:25] when enabled.
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7].
  - U: imm[31:12]→[31:12].
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12].
  - rd/rs1/rs2/funct3/opcode go in their standard positions; fields unused by a format are 0.
- Range checks (err=1 if violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - LI: never errors.
- LI expansion: hi=(req_imm+32'h800)[31:12], lo=req_imm[11:0]; addition is modulo 2^32.
  - hi=0: single ADDI rd,x0,lo.
  - lo=0 and hi≠0: single LUI rd,hi.
  - Otherwise: LUI rd,hi then ADDI rd,rd,lo.
  - Opcodes: LUI=7'h37; ADDI=7'h13, funct3=0.
- Invalid req_fmt encodings, or FMT_LI with ENABLE_LI=0: emit NOP 32'h00000013 with out_err=1, out_last=1.
- Reset asserted mid-LI: both words dropped. No output until a new request is accepted after reset deasserts.

Decomposition:
- Package rv_enc_pkg: fmt_e enum (3-bit), opcode constants (OP_LUI, OP_IMM, OP_JAL, OP_BRANCH, OP_STORE), NOP constant.
- Sub-module imm_pack: purely combinational; (fmt, imm, fields) → inst[31:0] + range_err. The top-level holds the FSM, output register and LI split logic.

Test Plan:
- FMT_I, opcode 7'h13, rd=5, rs1=0, funct3=0, imm=-1 → out_inst=32'hFFF00293, out_err=0, out_last=1, one cycle after accept.
- FMT_B, opcode 7'h63, rs1=1, rs2=2, funct3=0, imm=8 → 32'h00208463. Repeat with imm=7 → out_err=1.
- FMT_J, opcode 7'h6F, rd=1, imm=2048 → 32'h001000EF. Repeat with imm=32'h00100000 → out_err=1.
- FMT_LI, rd=10, imm=32'h12345FFF → 32'h12346537 (out_last=0), then 32'hFFF50513 (out_last=1). req_ready=0 while LI_HI is held.
- FMT_LI, imm=32'h00000123 → single 32'h12300513. Then imm=32'h00005000 → single 32'h00005537.
- Stalls and reset: back-to-back FMT_I with out_ready=1 gives 1 word/cycle. Hold out_ready=0 for 3 cycles during LI_HI → out_inst stable. Assert reset in LI_HI → out_valid=0 next edge and the ADDI word is never emitted.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the runtime RV32I instruction encoder.
// Formats, fixed opcodes and the output FSM state encoding live here.
package rv_enc_pkg;

   typedef enum logic [2:0] {
      FMT_I  = 3'd0,
      FMT_S  = 3'd1,
      FMT_B  = 3'd2,
      FMT_U  = 3'd3,
      FMT_J  = 3'd4,
      FMT_LI = 3'd5
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SINGLE = 2'd1,
      ST_LI_HI  = 2'd2,
      ST_LI_LO  = 2'd3
   } state_e;

   localparam logic [6:0]  OP_LUI    = 7'h37;
   localparam logic [6:0]  OP_IMM    = 7'h13;
   localparam logic [6:0]  OP_JAL    = 7'h6F;
   localparam logic [6:0]  OP_BRANCH = 7'h63;
   localparam logic [6:0]  OP_STORE  = 7'h23;
   localparam logic [31:0] NOP       = 32'h0000_0013;

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: scatters an immediate and register fields into
// one RV32I word of the selected format and flags unrepresentable immediates.
module imm_pack
   import rv_enc_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic        funct7_en,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        range_err
);

   logic fits_12, fits_13, fits_21;

   // A field of N bits holds imm iff every bit above the field's sign bit matches it.
   assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      inst      = NOP;
      range_err = 1'b1;
      case (fmt_e'(fmt))
         FMT_I: begin
            inst      = {imm[11:0], rs1, funct3, rd, opcode};
            if (funct7_en) inst[31:25] = funct7;
            range_err = ~fits_12;
         end
         FMT_S: begin
            inst      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            range_err = ~fits_12;
         end
         FMT_B: begin
            inst      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            range_err = ~fits_13 | imm[0];
         end
         FMT_U: begin
            inst      = {imm[31:12], rd, opcode};
            range_err = |imm[11:0];
         end
         FMT_J: begin
            inst      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            range_err = ~fits_21 | imm[0];
         end
         default: begin
            // LI is handled by the caller; anything else becomes a flagged NOP.
            inst      = NOP;
            range_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_inst_encoder.sv
// Runtime RV32I instruction encoder with LI expansion into LUI+ADDI.
// Single-entry registered output; req_ready = ~out_valid | (out_ready & out_last).
module imm_inst_encoder
   import rv_enc_pkg::*;
#(
   parameter bit ENABLE_LI   = 1'b1,
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_fmt,
   input  logic [6:0]  req_opcode,
   input  logic [2:0]  req_funct3,
   input  logic [6:0]  req_funct7,
   input  logic        req_funct7_en,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_last,
   output logic        out_err
);

   state_e      state_q, state_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] inst_d;
   logic        last_d, err_d;
   logic [31:0] pack_inst;
   logic        pack_err;
   logic [31:0] first_inst, addi_rd;
   logic        first_err, two_word, accept;
   logic [19:0] li_hi;
   logic [11:0] li_lo;

   imm_pack u_pack (
      .fmt       (req_fmt),
      .opcode    (req_opcode),
      .funct3    (req_funct3),
      .funct7    (req_funct7),
      .funct7_en (req_funct7_en),
      .rd        (req_rd),
      .rs1       (req_rs1),
      .rs2       (req_rs2),
      .imm       (req_imm),
      .inst      (pack_inst),
      .range_err (pack_err)
   );

   // Rounding the upper part by bit 11 compensates for ADDI sign-extending lo.
   assign li_hi   = req_imm[31:12] + {19'd0, req_imm[11]};
   assign li_lo   = req_imm[11:0];
   assign addi_rd = {li_lo, req_rd, 3'd0, req_rd, OP_IMM};

   always_comb begin
      first_inst = pack_inst;
      first_err  = CHECK_RANGE ? pack_err : 1'b0;
      two_word   = 1'b0;
      if (ENABLE_LI && (req_fmt == FMT_LI)) begin
         first_err = 1'b0;
         if (li_hi == 20'd0) begin
            first_inst = {li_lo, 5'd0, 3'd0, req_rd, OP_IMM};
         end else begin
            first_inst = {li_hi, req_rd, OP_LUI};
            two_word   = (li_lo != 12'd0);
         end
      end
   end

   assign out_valid = (state_q != ST_IDLE);
   assign req_ready = ~out_valid | (out_ready & out_last);
   assign accept    = req_valid & req_ready;

   always_comb begin
      state_d = state_q;
      inst_d  = out_inst;
      last_d  = out_last;
      err_d   = out_err;
      lo_d    = lo_q;
      case (state_q)
         ST_LI_HI: begin
            if (out_ready) begin
               state_d = ST_LI_LO;
               inst_d  = lo_q;
               last_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         default: begin
            if (accept) begin
               state_d = two_word ? ST_LI_HI : ST_SINGLE;
               inst_d  = first_inst;
               last_d  = ~two_word;
               err_d   = first_err;
               lo_d    = addi_rd;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         out_inst <= 32'd0;
         out_last <= 1'b0;
         out_err  <= 1'b0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         out_inst <= inst_d;
         out_last <= last_d;
         out_err  <= err_d;
         lo_q     <= lo_d;
      end
   end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Bench for imm_inst_encoder: directed cases with known encodings plus a
// randomized run against an arithmetic reference model and expected queue.
module tb_imm_inst_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_fmt;
   logic [6:0]  req_opcode;
   logic [2:0]  req_funct3;
   logic [6:0]  req_funct7;
   logic        req_funct7_en;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [31:0] req_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_last;
   logic        out_err;

   int pass_cnt  = 0;
   int check_cnt = 0;

   // {err, last, inst}
   logic [33:0] exp_q[$];

   imm_inst_encoder dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_fmt       (req_fmt),
      .req_opcode    (req_opcode),
      .req_funct3    (req_funct3),
      .req_funct7    (req_funct7),
      .req_funct7_en (req_funct7_en),
      .req_rd        (req_rd),
      .req_rs1       (req_rs1),
      .req_rs2       (req_rs2),
      .req_imm       (req_imm),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_last      (out_last),
      .out_err       (out_err)
   );

   always #5 clk = ~clk;

   // ---------------- driver ----------------
   task automatic drive_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic f7en, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      req_fmt = fmt; req_opcode = op; req_funct3 = f3; req_funct7 = f7; req_funct7_en = f7en;
      req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic idle_cycle;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   task automatic model_push(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic f7en, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      logic [31:0] w, r_rd, r_rs1, r_rs2, r_f3, r_op, hi, lo;
      int          s;
      logic        err;
      r_rd = 32'(rd); r_rs1 = 32'(rs1); r_rs2 = 32'(rs2); r_f3 = 32'(f3); r_op = 32'(op);
      s = int'(imm);
      case (fmt)
         3'd0: begin
            w = ((imm & 32'hFFF) << 20) | (r_rs1 << 15) | (r_f3 << 12) | (r_rd << 7) | r_op;
            if (f7en) w = (w & 32'h01FF_FFFF) | (32'(f7) << 25);
            err = !(s >= -2048 && s <= 2047);
            exp_q.push_back({err, 1'b1, w});
         end
         3'd1: begin
            w = (((imm >> 5) & 32'h7F) << 25) | (r_rs2 << 20) | (r_rs1 << 15) | (r_f3 << 12)
              | ((imm & 32'h1F) << 7) | r_op;
            err = !(s >= -2048 && s <= 2047);
            exp_q.push_back({err, 1'b1, w});
         end
         3'd2: begin
            w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r_rs2 << 20)
              | (r_rs1 << 15) | (r_f3 << 12) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 32'h1) << 7) | r_op;
            err = !(s >= -4096 && s <= 4095 && (s % 2 == 0));
            exp_q.push_back({err, 1'b1, w});
         end
         3'd3: begin
            w = (imm & 32'hFFFF_F000) | (r_rd << 7) | r_op;
            err = ((imm & 32'hFFF) != 0);
            exp_q.push_back({err, 1'b1, w});
         end
         3'd4: begin
            w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (r_rd << 7) | r_op;
            err = !(s >= -1048576 && s <= 1048575 && (s % 2 == 0));
            exp_q.push_back({err, 1'b1, w});
         end
         3'd5: begin
            hi = (imm + 32'h800) >> 12;
            lo = imm & 32'hFFF;
            if (hi == 0) begin
               exp_q.push_back({1'b0, 1'b1, (lo << 20) | (r_rd << 7) | 32'h13});
            end else if (lo == 0) begin
               exp_q.push_back({1'b0, 1'b1, (hi << 12) | (r_rd << 7) | 32'h37});
            end else begin
               exp_q.push_back({1'b0, 1'b0, (hi << 12) | (r_rd << 7) | 32'h37});
               exp_q.push_back({1'b0, 1'b1, (lo << 20) | (r_rd << 15) | (r_rd << 7) | 32'h13});
            end
         end
         default: exp_q.push_back({1'b1, 1'b1, 32'h0000_0013});
      endcase
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
      req_fmt = 3'd0; req_opcode = 7'd0; req_funct3 = 3'd0; req_funct7 = 7'd0;
      req_funct7_en = 1'b0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst, req_ready} !== {3'b000, 32'd0, 1'b1})
         $display("FAIL reset: valid=%b last=%b err=%b inst=%h ready=%b, want 0 0 0 00000000 1",
                  out_valid, out_last, out_err, out_inst, req_ready);
      else pass_cnt++;
      reset = 1'b0;
      idle_cycle();
   endtask

   task automatic test_i_fmt;
      out_ready = 1'b1;
      drive_req(3'd0, 7'h13, 3'd0, 7'h00, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'hFFF0_0293})
         $display("FAIL i_addi: v/l/e=%b%b%b inst=%h, want 110 fff00293", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      drive_req(3'd0, 7'h13, 3'd5, 7'h20, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'h4033_5293})
         $display("FAIL i_srai: v/l/e=%b%b%b inst=%h, want 110 40335293", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      drive_req(3'd0, 7'h13, 3'd0, 7'h00, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048);
      check_cnt++;
      if ({out_valid, out_last, out_err} !== 3'b111)
         $display("FAIL i_range: v/l/e=%b%b%b, want 111", out_valid, out_last, out_err);
      else pass_cnt++;
      drive_req(3'd1, 7'h23, 3'd2, 7'h00, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'hFE20_AE23})
         $display("FAIL s_sw: v/l/e=%b%b%b inst=%h, want 110 fe20ae23", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      idle_cycle();
   endtask

   task automatic test_b_j_u;
      out_ready = 1'b1;
      drive_req(3'd2, 7'h63, 3'd0, 7'h00, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'h0020_8463})
         $display("FAIL b_ok: v/l/e=%b%b%b inst=%h, want 110 00208463", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      drive_req(3'd2, 7'h63, 3'd0, 7'h00, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
      check_cnt++;
      if ({out_valid, out_err} !== 2'b11)
         $display("FAIL b_odd: valid=%b err=%b, want 1 1", out_valid, out_err);
      else pass_cnt++;
      drive_req(3'd4, 7'h6F, 3'd0, 7'h00, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'h0010_00EF})
         $display("FAIL j_ok: v/l/e=%b%b%b inst=%h, want 110 001000ef", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      drive_req(3'd4, 7'h6F, 3'd0, 7'h00, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
      check_cnt++;
      if ({out_valid, out_err} !== 2'b11)
         $display("FAIL j_range: valid=%b err=%b, want 1 1", out_valid, out_err);
      else pass_cnt++;
      drive_req(3'd3, 7'h37, 3'd0, 7'h00, 1'b0, 5'd3, 5'd0, 5'd0, 32'h1234_5000);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'h1234_51B7})
         $display("FAIL u_ok: v/l/e=%b%b%b inst=%h, want 110 123451b7", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      drive_req(3'd3, 7'h37, 3'd0, 7'h00, 1'b0, 5'd3, 5'd0, 5'd0, 32'h1234_5001);
      check_cnt++;
      if ({out_valid, out_err} !== 2'b11)
         $display("FAIL u_align: valid=%b err=%b, want 1 1", out_valid, out_err);
      else pass_cnt++;
      drive_req(3'd7, 7'h33, 3'd1, 7'h00, 1'b0, 5'd4, 5'd4, 5'd4, 32'd0);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b111, 32'h0000_0013})
         $display("FAIL bad_fmt: v/l/e=%b%b%b inst=%h, want 111 00000013", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      idle_cycle();
   endtask

   task automatic test_li;
      out_ready = 1'b1;
      drive_req(3'd5, 7'h00, 3'd0, 7'h00, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst, req_ready} !== {3'b100, 32'h1234_6537, 1'b0})
         $display("FAIL li_hi: v/l/e=%b%b%b inst=%h ready=%b, want 100 12346537 0",
                  out_valid, out_last, out_err, out_inst, req_ready);
      else pass_cnt++;
      idle_cycle();
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'hFFF5_0513})
         $display("FAIL li_lo: v/l/e=%b%b%b inst=%h, want 110 fff50513", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      drive_req(3'd5, 7'h00, 3'd0, 7'h00, 1'b0, 5'd10, 5'd0, 5'd0, 32'h0000_0123);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'h1230_0513})
         $display("FAIL li_addi_only: v/l/e=%b%b%b inst=%h, want 110 12300513", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      drive_req(3'd5, 7'h00, 3'd0, 7'h00, 1'b0, 5'd10, 5'd0, 5'd0, 32'h0000_5000);
      check_cnt++;
      if ({out_valid, out_last, out_err, out_inst} !== {3'b110, 32'h0000_5537})
         $display("FAIL li_lui_only: v/l/e=%b%b%b inst=%h, want 110 00005537", out_valid, out_last, out_err, out_inst);
      else pass_cnt++;
      idle_cycle();
      check_cnt++;
      if (out_valid !== 1'b0)
         $display("FAIL li_drain: valid=%b, want 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      logic [31:0] want;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_req(3'd0, 7'h13, 3'd0, 7'h00, 1'b0, 5'(i + 1), 5'd2, 5'd0, 32'(i * 3));
         want = (32'(i * 3) << 20) | (32'd2 << 15) | (32'(i + 1) << 7) | 32'h13;
         check_cnt++;
         if ({out_valid, out_last, out_inst} !== {2'b11, want})
            $display("FAIL b2b[%0d]: valid=%b last=%b inst=%h, want 1 1 %h", i, out_valid, out_last, out_inst, want);
         else pass_cnt++;
      end
      idle_cycle();
   endtask

   task automatic test_li_stall;
      out_ready = 1'b0;
      drive_req(3'd5, 7'h00, 3'd0, 7'h00, 1'b0, 5'd7, 5'd0, 5'd0, 32'hDEAD_BEEF);
      // hi = 0xDEADC, lo = 0xEEF
      for (int i = 0; i < 3; i++) begin
         idle_cycle();
         check_cnt++;
         if ({out_valid, out_last, out_inst, req_ready} !== {2'b10, 32'hDEAD_C3B7, 1'b0})
            $display("FAIL stall_hold[%0d]: valid=%b last=%b inst=%h ready=%b, want 1 0 deadc3b7 0",
                     i, out_valid, out_last, out_inst, req_ready);
         else pass_cnt++;
      end
      out_ready = 1'b1;
      idle_cycle();
      check_cnt++;
      if ({out_valid, out_last, out_inst} !== {2'b11, 32'hEEF3_8393})
         $display("FAIL stall_lo: valid=%b last=%b inst=%h, want 1 1 eef38393", out_valid, out_last, out_inst);
      else pass_cnt++;
      idle_cycle();
   endtask

   task automatic test_reset_mid_li;
      out_ready = 1'b0;
      drive_req(3'd5, 7'h00, 3'd0, 7'h00, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
      reset = 1'b1;
      idle_cycle();
      check_cnt++;
      if ({out_valid, out_inst} !== {1'b0, 32'd0})
         $display("FAIL reset_mid_li: valid=%b inst=%h, want 0 00000000", out_valid, out_inst);
      else pass_cnt++;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle_cycle();
         check_cnt++;
         if (out_valid !== 1'b0)
            $display("FAIL reset_no_lo[%0d]: valid=%b inst=%h, want valid 0", i, out_valid, out_inst);
         else pass_cnt++;
      end
   endtask

   task automatic check_cycle(input string tag);
      check_cnt++;
      if (out_valid !== (exp_q.size() > 0))
         $display("FAIL %s_valid: got %b, want %b", tag, out_valid, exp_q.size() > 0);
      else pass_cnt++;
      if (exp_q.size() > 0) begin
         check_cnt++;
         if ({out_err, out_last, out_inst} !== exp_q[0])
            $display("FAIL %s_word: err/last/inst=%b %b %h, want %b %b %h", tag,
                     out_err, out_last, out_inst, exp_q[0][33], exp_q[0][32], exp_q[0][31:0]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random;
      logic        exp_rdy;
      logic [31:0] imm;
      exp_q.delete();
      @(negedge clk);
      for (int cyc = 0; cyc < 500; cyc++) begin
         check_cycle("rand");
         out_ready = ($urandom_range(0, 3) != 0);
         req_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = $urandom & 32'hFFFF_F000;
            default: imm = 32'($urandom_range(0, 4095));
         endcase
         req_fmt = 3'($urandom_range(0, 7)); req_opcode = 7'($urandom);
         req_funct3 = 3'($urandom); req_funct7 = 7'($urandom); req_funct7_en = 1'($urandom);
         req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom); req_imm = imm;
         #1;
         exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q[0][32]);
         check_cnt++;
         if (req_ready !== exp_rdy)
            $display("FAIL rand_ready: got %b, want %b (cycle %0d)", req_ready, exp_rdy, cyc);
         else pass_cnt++;
         if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
         if (req_valid && exp_rdy)
            model_push(req_fmt, req_opcode, req_funct3, req_funct7, req_funct7_en,
                       req_rd, req_rs1, req_rs2, req_imm);
         @(negedge clk);
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_cycle("drain");
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_i_fmt();
      test_b_j_u();
      test_li();
      test_back_to_back();
      test_li_stall();
      test_reset_mid_li();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
